// File: rtl/shift_reg_universal_pkg.sv
// shift_pkg: shared types and next-value logic for shift_reg_universal.
//   op_e    : 3-bit direct operation code (HOLD, LOAD, SHR, SHL, ROR, ROL, CLEAR, HOLD)
//   state_e : framed-transfer FSM states (IDLE, SHIFT, DONE)
//   shift_next() : combinational next register value for one operation,
//                  computed on a MAX_WIDTH-bit container and masked to the
//                  live register width.
package shift_pkg;

  // Largest register width the shared next-value function supports.
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_SHR   = 3'd2,
    OP_SHL   = 3'd3,
    OP_ROR   = 3'd4,
    OP_ROL   = 3'd5,
    OP_CLEAR = 3'd6,
    OP_HOLD7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // The register lives in the low `width` bits of a MAX_WIDTH container.
  // Instead of indexing bit width-1 directly, a one-hot `top` vector marks
  // the register MSB so serial/rotate bits can be OR-ed into place.
  function automatic logic [MAX_WIDTH-1:0] shift_next(
    input op_e                  op,
    input logic [MAX_WIDTH-1:0] q,
    input logic [MAX_WIDTH-1:0] din,
    input logic                 sin,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] top;
    logic [MAX_WIDTH-1:0] r;
    logic                 q_msb;
    mask  = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    top   = MAX_WIDTH'(1) << (width - 1);
    q_msb = ((q & top) != '0);
    r     = q;
    case (op)
      OP_LOAD:  r = din;
      OP_SHR:   r = (q >> 1) | (sin  ? top : '0);
      OP_SHL:   r = (q << 1) | MAX_WIDTH'(sin);
      OP_ROR:   r = (q >> 1) | (q[0] ? top : '0);
      OP_ROL:   r = (q << 1) | MAX_WIDTH'(q_msb);
      OP_CLEAR: r = '0;
      default:  r = q;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/shift_reg_universal_if.sv
// shift_reg_universal_if: control/data bundle of the universal shift register.
//   en, op, start, sin, din : driven by the controlling side (master)
//   q, sout, busy, done     : driven by the shift register (slave)
interface shift_reg_universal_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [2:0]       op;
  logic             start;
  logic             sin;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output en, op, start, sin, din,
    input  q, sout, busy, done
  );

  modport slave (
    input  en, op, start, sin, din,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_reg_universal.sv
// shift_reg_universal: universal shift register with framed serial transfer.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears q and returns to IDLE
//   bus   : shift_reg_universal_if slave port
//     en/op      direct operation (IDLE only, start low)
//     start      launch a WIDTH-bit frame: load din, then shift WIDTH times
//     sin        serial input, din parallel load data
//     q          register contents; sout serial output taken from q
//     busy       high while shifting; done one-cycle pulse after a frame
// Parameters: WIDTH (>=2), MSB_FIRST (0: frame shifts right, 1: shifts left).
module shift_reg_universal
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_reg_universal_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("shift_reg_universal: WIDTH out of supported range");
    end
  endgenerate

  // Frame shift direction is fixed at elaboration.
  localparam op_e FRAME_OP = MSB_FIRST ? OP_SHL : OP_SHR;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [CW-1:0]    count, count_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      q_r   <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      q_r   <= q_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    count_nxt = count;
    case (state)
      S_IDLE: begin
        // start outranks any direct op presented on the same edge.
        if (bus.start) begin
          q_nxt     = bus.din;
          count_nxt = '0;
          state_nxt = S_SHIFT;
        end else if (bus.en) begin
          q_nxt = WIDTH'(shift_next(op_e'(bus.op), MAX_WIDTH'(q_r),
                                    MAX_WIDTH'(bus.din), bus.sin, WIDTH));
        end
      end
      S_SHIFT: begin
        q_nxt = WIDTH'(shift_next(FRAME_OP, MAX_WIDTH'(q_r),
                                  MAX_WIDTH'(bus.din), bus.sin, WIDTH));
        if (count == CW'(WIDTH - 1)) begin
          count_nxt = '0;
          state_nxt = S_DONE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.q    = q_r;
  assign bus.sout = MSB_FIRST ? q_r[WIDTH-1] : q_r[0];
  assign bus.busy = (state == S_SHIFT);
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       en = 1'b0, start = 1'b0, sin = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] din = 4'd0;

  shift_reg_universal_if #(.WIDTH(4)) bus0 ();
  shift_reg_universal_if #(.WIDTH(4)) bus1 ();

  assign bus0.en = en;  assign bus0.op = op;  assign bus0.start = start;
  assign bus0.sin = sin; assign bus0.din = din;
  assign bus1.en = en;  assign bus1.op = op;  assign bus1.start = start;
  assign bus1.sin = sin; assign bus1.din = din;

  shift_reg_universal #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  shift_reg_universal #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int total = 0;
  int bad   = 0;
  int done_cnt0 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: register value as an integer, a frame is "shifts left
  // to do" plus a done flag. Index 0 = LSB-first unit, 1 = MSB-first unit.
  int mq[2];
  int left[2];
  bit mdone[2];

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int v;
      v = mq[d];
      if (reset) begin
        v = 0; left[d] = 0; mdone[d] = 0;
      end else if (mdone[d]) begin
        mdone[d] = 0;
      end else if (left[d] > 0) begin
        if (d == 1) v = (v * 2 + int'(sin)) % 16;
        else        v = v / 2 + (sin ? 8 : 0);
        left[d]--;
        if (left[d] == 0) mdone[d] = 1;
      end else if (start) begin
        v = int'(din); left[d] = 4;
      end else if (en) begin
        case (int'(op))
          1: v = int'(din);
          2: v = v / 2 + (sin ? 8 : 0);
          3: v = (v * 2 + int'(sin)) % 16;
          4: v = v / 2 + (v % 2) * 8;
          5: v = (v * 2) % 16 + v / 8;
          6: v = 0;
          default: ;
        endcase
      end
      mq[d] = v;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin mq[d] = 0; left[d] = 0; mdone[d] = 0; end
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("q0",    int'(bus0.q),    mq[0]);
      chk("busy0", int'(bus0.busy), int'(left[0] > 0));
      chk("done0", int'(bus0.done), int'(mdone[0]));
      chk("sout0", int'(bus0.sout), mq[0] % 2);
      chk("q1",    int'(bus1.q),    mq[1]);
      chk("busy1", int'(bus1.busy), int'(left[1] > 0));
      chk("done1", int'(bus1.done), int'(mdone[1]));
      chk("sout1", int'(bus1.sout), mq[1] / 8);
      if (bus0.done) done_cnt0++;
    end
  end

  task automatic cyc(input bit r, input bit e, input logic [2:0] o,
                     input bit s, input bit si, input logic [3:0] d);
    @(negedge clk);
    reset = r; en = e; op = o; start = s; sin = si; din = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int dc;
    cyc(1, 0, 0, 0, 0, 4'h0);
    cyc(1, 1, 1, 1, 1, 4'hF);
    chk("lit_reset_q", int'(bus0.q), 0);
    chk("lit_reset_busy", int'(bus0.busy), 0);
    chk("lit_reset_done", int'(bus1.done), 0);

    // Direct operations
    cyc(0, 1, 3'd1, 0, 0, 4'b1011); chk("lit_load", int'(bus0.q), 4'b1011);
    cyc(0, 1, 3'd2, 0, 0, 4'h0);    chk("lit_shr",  int'(bus0.q), 4'b0101);
    cyc(0, 1, 3'd3, 0, 1, 4'h0);    chk("lit_shl",  int'(bus0.q), 4'b1011);
    cyc(0, 1, 3'd4, 0, 0, 4'h0);    chk("lit_ror",  int'(bus0.q), 4'b1101);
    cyc(0, 1, 3'd5, 0, 0, 4'h0);    chk("lit_rol",  int'(bus0.q), 4'b1011);
    cyc(0, 1, 3'd6, 0, 0, 4'h0);    chk("lit_clear", int'(bus0.q), 4'b0000);
    cyc(0, 1, 3'd1, 0, 0, 4'b1011);
    cyc(0, 0, 3'd1, 0, 0, 4'b1111); chk("lit_en0",  int'(bus0.q), 4'b1011);
    cyc(0, 1, 3'd7, 0, 1, 4'b1111); chk("lit_op7",  int'(bus1.q), 4'b1011);

    // Frame A: din=1001, sin 1,1,0,1; ops/start presented mid-frame
    cyc(0, 0, 3'd0, 1, 0, 4'b1001); chk("lit_fa_sout_b0", int'(bus0.sout), 1);
    chk("lit_fa_busy", int'(bus0.busy), 1);
    cyc(0, 1, 3'd6, 0, 1, 4'h0);    chk("lit_fa_sout_b1", int'(bus0.sout), 0);
    cyc(0, 1, 3'd6, 0, 1, 4'h0);    chk("lit_fa_sout_b2", int'(bus0.sout), 0);
    cyc(0, 1, 3'd1, 1, 0, 4'hF);    chk("lit_fa_sout_b3", int'(bus0.sout), 1);
    cyc(0, 1, 3'd6, 1, 1, 4'h0);
    chk("lit_fa_q0", int'(bus0.q), 4'b1011);
    chk("lit_fa_q1", int'(bus1.q), 4'b1101);
    chk("lit_fa_done", int'(bus0.done), 1);
    chk("lit_fa_busy_end", int'(bus0.busy), 0);
    cyc(0, 1, 3'd6, 1, 0, 4'h5);    // start/op in DONE ignored
    chk("lit_fa_idle_busy", int'(bus0.busy), 0);
    chk("lit_fa_idle_done", int'(bus0.done), 0);
    chk("lit_fa_hold_q", int'(bus0.q), 4'b1011);

    // Frame B: din=1100, sin 0,1,1,1
    cyc(0, 0, 3'd0, 1, 0, 4'b1100); chk("lit_fb_sout_b0", int'(bus1.sout), 1);
    cyc(0, 0, 3'd0, 0, 0, 4'h0);    chk("lit_fb_sout_b1", int'(bus1.sout), 1);
    cyc(0, 0, 3'd0, 0, 1, 4'h0);    chk("lit_fb_sout_b2", int'(bus1.sout), 0);
    cyc(0, 0, 3'd0, 0, 1, 4'h0);    chk("lit_fb_sout_b3", int'(bus1.sout), 0);
    cyc(0, 0, 3'd0, 0, 1, 4'h0);
    chk("lit_fb_q1", int'(bus1.q), 4'b0111);
    chk("lit_fb_q0", int'(bus0.q), 4'b1110);
    chk("lit_fb_done", int'(bus1.done), 1);
    cyc(0, 0, 3'd0, 0, 0, 4'h0);

    // start with CLEAR in IDLE, then reset during the second shift
    cyc(0, 1, 3'd6, 1, 0, 4'b0110); chk("lit_start_over_clear", int'(bus0.q), 4'b0110);
    cyc(0, 0, 3'd0, 0, 1, 4'h0);
    dc = done_cnt0;
    cyc(1, 0, 3'd0, 0, 1, 4'h0);
    chk("lit_rst_q", int'(bus0.q), 0);
    chk("lit_rst_busy", int'(bus0.busy), 0);
    cyc(0, 0, 3'd0, 1, 1, 4'b1010); chk("lit_restart_q", int'(bus0.q), 4'b1010);
    cyc(0, 0, 3'd0, 0, 1, 4'h0);
    chk("lit_rst_no_done", done_cnt0, dc);
    cyc(0, 0, 3'd0, 0, 0, 4'h0);
    cyc(0, 0, 3'd0, 0, 1, 4'h0);
    cyc(0, 0, 3'd0, 0, 0, 4'h0);
    chk("lit_restart_done", done_cnt0, dc + 1);
    cyc(0, 0, 3'd0, 0, 0, 4'h0);

    // start held high: frames every WIDTH+2 cycles
    dc = done_cnt0;
    for (int i = 0; i < 13; i++) cyc(0, 1, 3'd6, 1, i[0] ^ i[1], 4'(i + 3));
    chk("lit_held_start_dones", done_cnt0 - dc, 2);
    for (int i = 0; i < 8; i++) cyc(0, 0, 3'd0, 0, i[0], 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
